// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard table datapath.
package billiard_pkg;

    localparam int BALL_DIAMETER = 32;
    localparam int VEL_FRAC_BITS = 6;

    typedef logic signed [10:0] vel_t;
    typedef logic [16:0]        pos_fx_t;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        UPD_POS,
        UPD_VEL
    } motion_state_t;

    // One friction step: move a velocity component 1 toward zero.
    function automatic vel_t friction_step(input vel_t v);
        if (v > vel_t'(0))
            return v - vel_t'(1);
        else if (v < vel_t'(0))
            return v + vel_t'(1);
        return v;
    endfunction

endpackage

// File: rtl/ball_motion_axis_integrator.sv
// One axis of ball kinematics: fixed-point position with edge clamp, velocity with friction.
module axis_integrator
    import billiard_pkg::*;
#(
    parameter int MIN  = 24,
    parameter int MAX  = 616,
    parameter int INIT = 100
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        doPos,
    input  logic        doFric,
    input  logic        loadVel,
    input  vel_t        loadVal,
    output logic [10:0] posInt,
    output vel_t        vel
);

    localparam logic [10:0] MIN_I   = 11'(MIN);
    localparam logic [10:0] HI_I    = 11'(MAX - BALL_DIAMETER);
    localparam pos_fx_t     INIT_FX = {11'(INIT), {VEL_FRAC_BITS{1'b0}}};

    pos_fx_t     pos_q, pos_d;
    vel_t        vel_q, vel_d;
    logic [17:0] sum;
    logic [10:0] sum_int;

    // sum[17] set means the step went below zero, which counts as below MIN.
    always_comb begin
        sum     = {1'b0, pos_q} + {{7{vel_q[10]}}, vel_q};
        sum_int = sum[16:VEL_FRAC_BITS];
        pos_d   = pos_q;
        if (doPos) begin
            if (sum[17] || sum_int < MIN_I)
                pos_d = {MIN_I, {VEL_FRAC_BITS{1'b0}}};
            else if (sum_int > HI_I)
                pos_d = {HI_I, {VEL_FRAC_BITS{1'b0}}};
            else
                pos_d = sum[16:0];
        end

        vel_d = vel_q;
        if (doFric)
            vel_d = friction_step(vel_q);
        if (loadVel)
            vel_d = loadVal;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pos_q <= INIT_FX;
            vel_q <= '0;
        end else begin
            pos_q <= pos_d;
            vel_q <= vel_d;
        end
    end

    assign posInt = pos_q[16:VEL_FRAC_BITS];
    assign vel    = vel_q;

endmodule

// File: rtl/ball_motion.sv
// Per-ball motion controller: launch/collision velocity loads and the per-frame update sequence.
module ball_motion
    import billiard_pkg::*;
#(
    parameter int          INIT_X          = 100,
    parameter int          INIT_Y          = 200,
    parameter int          X_MIN           = 24,
    parameter int          X_MAX           = 616,
    parameter int          Y_MIN           = 24,
    parameter int          Y_MAX           = 456,
    parameter int unsigned FRICTION_PERIOD = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        launch,
    input  vel_t        launchVelX,
    input  vel_t        launchVelY,
    input  logic        collisionOccurred,
    input  vel_t        collVelX,
    input  vel_t        collVelY,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output vel_t        velX,
    output vel_t        velY,
    output logic        moving
);

    localparam logic [15:0] FRIC_LAST = 16'(FRICTION_PERIOD - 1);

    motion_state_t state_q, state_d;
    logic [15:0]   fric_cnt_q, fric_cnt_d;
    logic          pend_q, pend_d;
    vel_t          pend_vx_q, pend_vx_d, pend_vy_q, pend_vy_d;
    logic          moving_q, moving_d;

    logic do_pos, do_fric, load_vel;
    vel_t load_vx, load_vy, next_vx, next_vy;
    vel_t vel_x, vel_y;

    always_comb begin
        state_d    = state_q;
        fric_cnt_d = fric_cnt_q;
        pend_d     = pend_q;
        pend_vx_d  = pend_vx_q;
        pend_vy_d  = pend_vy_q;
        do_pos     = 1'b0;
        do_fric    = 1'b0;
        load_vel   = 1'b0;
        load_vx    = collVelX;
        load_vy    = collVelY;
        next_vx    = '0;
        next_vy    = '0;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    load_vel   = 1'b1;
                    load_vx    = launchVelX;
                    load_vy    = launchVelY;
                    fric_cnt_d = '0;
                    if (launchVelX != '0 || launchVelY != '0)
                        state_d = MOVING;
                end
            end
            MOVING: begin
                load_vel = collisionOccurred;
                if (startOfFrame)
                    state_d = UPD_POS;
            end
            UPD_POS: begin
                do_pos  = 1'b1;
                state_d = UPD_VEL;
                if (collisionOccurred) begin
                    pend_d    = 1'b1;
                    pend_vx_d = collVelX;
                    pend_vy_d = collVelY;
                end
            end
            UPD_VEL: begin
                do_fric    = (fric_cnt_q == FRIC_LAST);
                fric_cnt_d = do_fric ? '0 : fric_cnt_q + 16'd1;
                // A collision landing in this very cycle is newer than the pending one.
                if (collisionOccurred) begin
                    load_vel = 1'b1;
                end else if (pend_q) begin
                    load_vel = 1'b1;
                    load_vx  = pend_vx_q;
                    load_vy  = pend_vy_q;
                end
                pend_d  = 1'b0;
                next_vx = load_vel ? load_vx : (do_fric ? friction_step(vel_x) : vel_x);
                next_vy = load_vel ? load_vy : (do_fric ? friction_step(vel_y) : vel_y);
                state_d = (next_vx == '0 && next_vy == '0) ? IDLE : MOVING;
            end
            default: state_d = IDLE;
        endcase

        moving_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            fric_cnt_q <= '0;
            pend_q     <= 1'b0;
            pend_vx_q  <= '0;
            pend_vy_q  <= '0;
            moving_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fric_cnt_q <= fric_cnt_d;
            pend_q     <= pend_d;
            pend_vx_q  <= pend_vx_d;
            pend_vy_q  <= pend_vy_d;
            moving_q   <= moving_d;
        end
    end

    axis_integrator #(.MIN(X_MIN), .MAX(X_MAX), .INIT(INIT_X)) u_axis_x (
        .clk     (clk),
        .resetN  (resetN),
        .doPos   (do_pos),
        .doFric  (do_fric),
        .loadVel (load_vel),
        .loadVal (load_vx),
        .posInt  (topLeftX),
        .vel     (vel_x)
    );

    axis_integrator #(.MIN(Y_MIN), .MAX(Y_MAX), .INIT(INIT_Y)) u_axis_y (
        .clk     (clk),
        .resetN  (resetN),
        .doPos   (do_pos),
        .doFric  (do_fric),
        .loadVel (load_vel),
        .loadVal (load_vy),
        .posInt  (topLeftY),
        .vel     (vel_y)
    );

    assign velX   = vel_x;
    assign velY   = vel_y;
    assign moving = moving_q;

endmodule

// File: tb/tb_ball_motion.sv
// Random and directed checks of ball_motion against a frame-level arithmetic model.
module tb_ball_motion;

    localparam int PH_REST = 0;
    localparam int PH_ROLL = 1;
    localparam int PH_POS  = 2;
    localparam int PH_VEL  = 3;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    logic startOfFrame = 1'b0;
    logic launch = 1'b0;
    logic collisionOccurred = 1'b0;
    logic signed [10:0] launchVelX = '0, launchVelY = '0;
    logic signed [10:0] collVelX = '0, collVelY = '0;

    logic [10:0]        tlx [2];
    logic [10:0]        tly [2];
    logic signed [10:0] vx  [2];
    logic signed [10:0] vy  [2];
    logic               mv  [2];

    int n_vec = 0;
    int n_err = 0;

    int period [2] = '{4, 1000};
    int m_px [2], m_py [2], m_vx [2], m_vy [2], m_cnt [2];
    int m_phase [2], m_pend [2], m_pvx [2], m_pvy [2];

    always #5 clk = ~clk;

    ball_motion u_dut_fast (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .launch(launch),
        .launchVelX(launchVelX), .launchVelY(launchVelY),
        .collisionOccurred(collisionOccurred), .collVelX(collVelX), .collVelY(collVelY),
        .topLeftX(tlx[0]), .topLeftY(tly[0]), .velX(vx[0]), .velY(vy[0]), .moving(mv[0])
    );

    ball_motion #(.FRICTION_PERIOD(1000)) u_dut_slow (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .launch(launch),
        .launchVelX(launchVelX), .launchVelY(launchVelY),
        .collisionOccurred(collisionOccurred), .collVelX(collVelX), .collVelY(collVelY),
        .topLeftX(tlx[1]), .topLeftY(tly[1]), .velX(vx[1]), .velY(vy[1]), .moving(mv[1])
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int toward_zero(input int v);
        if (v > 0) return v - 1;
        if (v < 0) return v + 1;
        return 0;
    endfunction

    // Position in 1/64 px; the ball's top-left may range over [lo, hi-32] whole pixels.
    function automatic int clamp_fx(input int p, input int lo, input int hi);
        if (p < lo * 64) return lo * 64;
        if (p >= (hi - 32 + 1) * 64) return (hi - 32) * 64;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_px[i] = 100 * 64; m_py[i] = 200 * 64;
            m_vx[i] = 0; m_vy[i] = 0; m_cnt[i] = 0;
            m_phase[i] = PH_REST; m_pend[i] = 0; m_pvx[i] = 0; m_pvy[i] = 0;
        end
    endtask

    task automatic model_step();
        int lvx, lvy, cvx, cvy;
        lvx = launchVelX; lvy = launchVelY; cvx = collVelX; cvy = collVelY;
        if (!resetN) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            case (m_phase[i])
                PH_REST: if (launch) begin
                    m_vx[i] = lvx; m_vy[i] = lvy; m_cnt[i] = 0;
                    if (lvx != 0 || lvy != 0) m_phase[i] = PH_ROLL;
                end
                PH_ROLL: begin
                    if (collisionOccurred) begin m_vx[i] = cvx; m_vy[i] = cvy; end
                    if (startOfFrame) m_phase[i] = PH_POS;
                end
                PH_POS: begin
                    m_px[i] = clamp_fx(m_px[i] + m_vx[i], 24, 616);
                    m_py[i] = clamp_fx(m_py[i] + m_vy[i], 24, 456);
                    if (collisionOccurred) begin m_pend[i] = 1; m_pvx[i] = cvx; m_pvy[i] = cvy; end
                    m_phase[i] = PH_VEL;
                end
                default: begin
                    if (m_cnt[i] == period[i] - 1) begin
                        m_vx[i] = toward_zero(m_vx[i]);
                        m_vy[i] = toward_zero(m_vy[i]);
                        m_cnt[i] = 0;
                    end else begin
                        m_cnt[i]++;
                    end
                    if (collisionOccurred) begin
                        m_vx[i] = cvx; m_vy[i] = cvy;
                    end else if (m_pend[i] != 0) begin
                        m_vx[i] = m_pvx[i]; m_vy[i] = m_pvy[i];
                    end
                    m_pend[i] = 0;
                    m_phase[i] = (m_vx[i] == 0 && m_vy[i] == 0) ? PH_REST : PH_ROLL;
                end
            endcase
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            string s;
            s = (i == 0) ? "fast" : "slow";
            check_eq({"x_", s}, int'(tlx[i]), m_px[i] / 64);
            check_eq({"y_", s}, int'(tly[i]), m_py[i] / 64);
            check_eq({"vx_", s}, int'(vx[i]), m_vx[i]);
            check_eq({"vy_", s}, int'(vy[i]), m_vy[i]);
            check_eq({"moving_", s}, int'(mv[i]), (m_phase[i] != PH_REST) ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        launch = 1'b0;
        startOfFrame = 1'b0;
        collisionOccurred = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #2;
        model_reset();
        check_all();
        check_eq("rst_x", int'(tlx[0]), 100);
        check_eq("rst_y", int'(tly[1]), 200);
        check_eq("rst_vx", int'(vx[0]), 0);
        check_eq("rst_moving", int'(mv[0]), 0);
        tick();
        resetN = 1'b1;
    endtask

    task automatic launch_ball(input int x, input int y);
        launch = 1'b1;
        launchVelX = 11'(x);
        launchVelY = 11'(y);
        tick();
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        tick();
        tick();
        tick();
    endtask

    task automatic collide(input int x, input int y);
        collisionOccurred = 1'b1;
        collVelX = 11'(x);
        collVelY = 11'(y);
    endtask

    function automatic int rand_vel();
        if ($urandom_range(0, 3) == 0)
            return int'($urandom_range(0, 6)) - 3;
        return int'($urandom_range(0, 2046)) - 1023;
    endfunction

    initial begin
        #1;
        do_reset();

        // Integration without friction
        launch_ball(64, 0);
        for (int f = 0; f < 10; f++) frame();
        check_eq("intg_x", int'(tlx[1]), 110);
        check_eq("intg_y", int'(tly[1]), 200);
        check_eq("intg_moving", int'(mv[1]), 1);

        // Friction brings the ball to rest
        do_reset();
        launch_ball(3, -2);
        for (int f = 1; f <= 11; f++) begin
            frame();
            if (f == 7) check_eq("fric_vy_f7", int'(vy[0]), -1);
            if (f == 8) check_eq("fric_vy_f8", int'(vy[0]), 0);
        end
        check_eq("fric_vx_f11", int'(vx[0]), 1);
        startOfFrame = 1'b1;
        tick();
        tick();
        check_eq("fric_mv_t1", int'(mv[0]), 1);
        tick();
        check_eq("fric_mv_t2", int'(mv[0]), 0);
        check_eq("fric_vx_f12", int'(vx[0]), 0);
        tick();

        // Right-edge clamp, then bounce off
        do_reset();
        launch_ball(960, 0);
        for (int f = 0; f < 32; f++) frame();
        check_eq("clamp_pre", int'(tlx[1]), 580);
        collide(512, 0);
        tick();
        check_eq("clamp_coll_vx", int'(vx[1]), 512);
        frame();
        check_eq("clamp_edge", int'(tlx[1]), 584);
        collide(-512, 0);
        tick();
        frame();
        check_eq("clamp_back", int'(tlx[1]), 576);

        // Collision in the same cycle as the frame strobe
        do_reset();
        launch_ball(64, 0);
        frame();
        frame();
        check_eq("coinc_pre", int'(tlx[0]), 102);
        startOfFrame = 1'b1;
        collide(-64, 0);
        tick();
        tick();
        check_eq("coinc_x", int'(tlx[0]), 101);
        tick();
        tick();

        // Collision during the update overrides friction
        do_reset();
        launch_ball(64, 10);
        frame();
        frame();
        frame();
        startOfFrame = 1'b1;
        tick();
        collide(64, 100);
        tick();
        tick();
        check_eq("upd_coll_vy", int'(vy[0]), 100);
        check_eq("upd_coll_vx", int'(vx[0]), 64);
        tick();

        // Launch while moving is ignored; reset in the velocity-update cycle
        do_reset();
        launch_ball(64, 0);
        frame();
        launch_ball(500, 500);
        check_eq("ign_launch_vx", int'(vx[0]), 64);
        check_eq("ign_launch_vy", int'(vy[0]), 0);
        startOfFrame = 1'b1;
        tick();
        tick();
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 99) < 8) begin
                launch = 1'b1;
                launchVelX = 11'(rand_vel());
                launchVelY = 11'(rand_vel());
            end
            startOfFrame = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 10)
                collide(rand_vel(), rand_vel());
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
